// File: rtl/decimating_averager_pkg.sv
// rtl/decimating_averager_pkg.sv - shared pt_feedback constants used by the decimating averager
package decimating_averager_pkg;

    // Register-bank reset value for the decimation ratio field (log2 samples per block).
    localparam int PT_FB_DEFAULT_LOG2_DEC = 3;

endpackage : decimating_averager_pkg

// File: rtl/decimating_averager.sv
// rtl/decimating_averager.sv - block-average decimator, emits the mean of 2^L valid samples
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   log2_dec_i    requested log2 decimation ratio (clamped to MAX_LOG2_DEC)
//   clear_i       synchronous restart, discards the partial block
//   data_valid_i  qualifies in_i
//   in_i          signed input sample
//   data_valid_o  one-cycle strobe, out_o holds a new mean
//   out_o         signed mean of the last completed block, held between strobes
module decimating_averager
    import decimating_averager_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int MAX_LOG2_DEC = 7,
    parameter int LOG2_W       = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LOG2_W-1:0] log2_dec_i,
    input  logic              clear_i,
    input  logic              data_valid_i,
    input  logic [WIDTH-1:0]  in_i,
    output logic              data_valid_o,
    output logic [WIDTH-1:0]  out_o
);

    // Sign-extended accumulator wide enough for 2^MAX_LOG2_DEC full-scale samples.
    localparam int ACC_W = WIDTH + MAX_LOG2_DEC;
    localparam int CNT_W = (MAX_LOG2_DEC > 0) ? MAX_LOG2_DEC : 1;
    localparam logic [LOG2_W-1:0] L_MAX = LOG2_W'(MAX_LOG2_DEC);

    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic [LOG2_W-1:0]       r_l;
    logic [WIDTH-1:0]        r_out;
    logic                    r_dv;

    logic [LOG2_W-1:0]       w_l_clamp;
    logic [LOG2_W-1:0]       w_l_eff;
    logic [CNT_W:0]          w_cnt_max;
    logic                    w_last;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [LOG2_W-1:0]       w_l_nxt;

    logic signed [ACC_W-1:0] w_in_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_mean;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic [WIDTH-1:0]        w_out_nxt;
    logic                    w_dv_nxt;

    assign w_l_clamp = (log2_dec_i > L_MAX) ? L_MAX : log2_dec_i;

    // The first sample of a block uses the freshly requested ratio, so a block
    // of any length (including L=0) is sized by the ratio present at its start.
    assign w_l_eff   = (r_cnt == '0) ? w_l_clamp : r_l;
    assign w_cnt_max = ((CNT_W+1)'(1) << w_l_eff) - (CNT_W+1)'(1);
    assign w_last    = ({1'b0, r_cnt} == w_cnt_max);

    // Counter and ratio latch.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_l_nxt   = r_l;
        if (clear_i) begin
            w_cnt_nxt = '0;
        end else if (data_valid_i) begin
            if (r_cnt == '0) begin
                w_l_nxt = w_l_clamp;
            end
            w_cnt_nxt = w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_l   <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_l   <= w_l_nxt;
        end
    end

    // Accumulator and output.
    assign w_in_ext = {{MAX_LOG2_DEC{in_i[WIDTH-1]}}, in_i};
    assign w_sum    = r_acc + w_in_ext;
    // Arithmetic shift floors toward -inf; the mean of WIDTH-bit samples fits in WIDTH bits.
    assign w_mean   = w_sum >>> w_l_eff;

    always_comb begin
        w_acc_nxt = r_acc;
        w_out_nxt = r_out;
        w_dv_nxt  = 1'b0;
        if (clear_i) begin
            w_acc_nxt = '0;
        end else if (data_valid_i) begin
            if (w_last) begin
                w_out_nxt = w_mean[WIDTH-1:0];
                w_dv_nxt  = 1'b1;
                w_acc_nxt = '0;
            end else begin
                w_acc_nxt = w_sum;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc <= '0;
            r_out <= '0;
            r_dv  <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_out <= w_out_nxt;
            r_dv  <= w_dv_nxt;
        end
    end

    assign out_o        = r_out;
    assign data_valid_o = r_dv;

endmodule : decimating_averager

// File: tb/tb_decimating_averager.sv
// tb/tb_decimating_averager.sv - directed self-checking bench for decimating_averager
module tb_decimating_averager;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  log2_dec_i = 3'd0;
    logic        clear_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic [15:0] in_i = 16'd0;
    logic        data_valid_o;
    logic [15:0] out_o;

    int n_vec  = 0;
    int n_miss = 0;
    int strobes = 0;
    int s0;
    logic               prev_dv;
    logic signed [15:0] prev_out;
    logic signed [15:0] last_strobe_out = 16'sd0;

    always #5 clk_i = ~clk_i;

    decimating_averager #(.WIDTH(16), .MAX_LOG2_DEC(7), .LOG2_W(3)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .log2_dec_i   (log2_dec_i),
        .clear_i      (clear_i),
        .data_valid_i (data_valid_i),
        .in_i         (in_i),
        .data_valid_o (data_valid_o),
        .out_o        (out_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: at the falling edge record the outputs produced by the
    // previous cycle's inputs, then apply this cycle's inputs.
    task automatic tick(input logic v, input int d, input logic clr, input logic rst);
        @(negedge clk_i);
        prev_dv  = data_valid_o;
        prev_out = out_o;
        if (prev_dv) begin
            strobes++;
            last_strobe_out = prev_out;
        end
        data_valid_i = v;
        in_i         = 16'(d);
        clear_i      = clr;
        rst_i        = rst;
    endtask

    initial begin
        // Reset
        tick(1'b0, 0, 1'b0, 1'b1);
        tick(1'b0, 0, 1'b0, 1'b1);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("reset_out", int'(prev_out), 0);
        check("reset_dv", int'(prev_dv), 0);

        // L=2: 4,8,12,16 -> 10, strobe on the cycle after 16
        log2_dec_i = 3'd2;
        s0 = strobes;
        tick(1'b1, 4, 1'b0, 1'b0);
        tick(1'b1, 8, 1'b0, 1'b0);
        tick(1'b1, 12, 1'b0, 1'b0);
        tick(1'b1, 16, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("l2_dv_latency", int'(prev_dv), 1);
        check("l2_mean", int'(prev_out), 10);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("l2_dv_one_cycle", int'(prev_dv), 0);
        check("l2_strobes", strobes - s0, 1);

        // L=3: eight full-scale negatives with gaps, then eight full-scale positives
        log2_dec_i = 3'd3;
        s0 = strobes;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, -32768, 1'b0, 1'b0);
            for (int g = 0; g < (i % 4); g++) tick(1'b0, 0, 1'b0, 1'b0);
        end
        tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("l3_neg_strobes", strobes - s0, 1);
        check("l3_neg_mean", int'(last_strobe_out), -32768);
        s0 = strobes;
        for (int i = 0; i < 8; i++) tick(1'b1, 32767, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("l3_pos_strobes", strobes - s0, 1);
        check("l3_pos_mean", int'(prev_out), 32767);

        // L=1: floor behaviour
        log2_dec_i = 3'd1;
        tick(1'b1, -1, 1'b0, 1'b0);
        tick(1'b1, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("l1_floor_dv", int'(prev_dv), 1);
        check("l1_floor_mean", int'(prev_out), -1);
        tick(1'b1, 1, 1'b0, 1'b0);
        tick(1'b1, 2, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("l1_pos_mean", int'(prev_out), 1);

        // L=0: pass-through ramp
        log2_dec_i = 3'd0;
        s0 = strobes;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, i, 1'b0, 1'b0);
            if (i > 0) begin
                check("l0_dv", int'(prev_dv), 1);
                check("l0_out", int'(prev_out), i - 1);
            end
        end
        tick(1'b0, 0, 1'b0, 1'b0);
        check("l0_last_out", int'(prev_out), 9);
        check("l0_strobes", strobes - s0, 10);

        // Ratio change mid-block: current block stays at 4, next uses 8
        log2_dec_i = 3'd2;
        s0 = strobes;
        tick(1'b1, 4, 1'b0, 1'b0);
        tick(1'b1, 4, 1'b0, 1'b0);
        log2_dec_i = 3'd3;
        tick(1'b1, 4, 1'b0, 1'b0);
        tick(1'b1, 4, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("chg_first_dv", int'(prev_dv), 1);
        check("chg_first_mean", int'(prev_out), 4);
        s0 = strobes;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 2 * i, 1'b0, 1'b0);
            if (i == 5) check("chg_no_early_strobe", strobes - s0, 0);
        end
        tick(1'b0, 0, 1'b0, 1'b0);
        check("chg_second_strobes", strobes - s0, 1);
        check("chg_second_mean", int'(prev_out), 9);

        // Clear with the 3rd sample, then a fresh block of ones
        log2_dec_i = 3'd2;
        s0 = strobes;
        tick(1'b1, 5, 1'b0, 1'b0);
        tick(1'b1, 5, 1'b0, 1'b0);
        tick(1'b1, 5, 1'b1, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("clr_no_strobe", strobes - s0, 0);
        check("clr_out_held", int'(prev_out), 9);
        for (int i = 0; i < 4; i++) tick(1'b1, 1, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("clr_next_strobes", strobes - s0, 1);
        check("clr_next_mean", int'(prev_out), 1);

        // Reset mid-block
        tick(1'b1, 7, 1'b0, 1'b0);
        tick(1'b1, 7, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b1);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("rst_mid_out", int'(prev_out), 0);
        check("rst_mid_dv", int'(prev_dv), 0);
        s0 = strobes;
        for (int i = 0; i < 3; i++) tick(1'b1, 8, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("rst_no_early_strobe", strobes - s0, 0);
        tick(1'b1, 8, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        check("rst_fresh_strobes", strobes - s0, 1);
        check("rst_fresh_mean", int'(prev_out), 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_decimating_averager
